// File: rtl/flash_sample_loader_if.sv
// Control and bus signals of flash_sample_loader, grouped for a single port.
// master = loader side; slave = environment (flash controller, sample RAM, controller).
interface flash_sample_loader_if #(
    parameter int SAMPLE_W = 16,
    parameter int MEM_AW   = 8,
    parameter int FLASH_AW = 23
);
    logic                start;
    logic [FLASH_AW-1:0] start_addr;
    logic                busy;
    logic                done;

    logic                flash_mem_read;
    logic [FLASH_AW-1:0] flash_mem_address;
    logic [3:0]          flash_mem_byteenable;
    logic                flash_mem_waitrequest;
    logic [31:0]         flash_mem_readdata;
    logic                flash_mem_readdatavalid;

    logic [MEM_AW-1:0]   s_mem_address;
    logic [SAMPLE_W-1:0] s_mem_data;
    logic                s_mem_wren;

    modport master (
        input  start, start_addr,
        input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        output busy, done,
        output flash_mem_read, flash_mem_address, flash_mem_byteenable,
        output s_mem_address, s_mem_data, s_mem_wren
    );

    modport slave (
        output start, start_addr,
        output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        input  busy, done,
        input  flash_mem_read, flash_mem_address, flash_mem_byteenable,
        input  s_mem_address, s_mem_data, s_mem_wren
    );
endinterface

// File: rtl/flash_sample_loader.sv
// Copies 2^MEM_AW/SPW flash words into sample memory, SPW samples per word, low lane first.
// Define FLASH_LOADER_OFFSET_BIN_EN to invert each sample MSB (two's complement -> offset binary).
module flash_sample_loader #(
    parameter int SAMPLE_W = 16,
    parameter int MEM_AW   = 8,
    parameter int FLASH_AW = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    flash_sample_loader_if.master bus
);
    localparam int SPW   = 32 / SAMPLE_W;
    localparam int WORDS = (1 << MEM_AW) / SPW;
    localparam logic [1:0]        LAST_LANE = 2'(SPW - 1);
    localparam logic [MEM_AW-1:0] LAST_WORD = MEM_AW'(WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [FLASH_AW-1:0] addr_q, addr_d;
    logic                read_q, read_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wren_q, wren_d;
    logic [1:0]          lane_q, lane_d;
    logic [MEM_AW-1:0]   word_q, word_d;
    logic [MEM_AW-1:0]   smp_q, smp_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic [31:0]         hold_q, hold_d;

    function automatic logic [SAMPLE_W-1:0] lane_sample(input logic [31:0] word,
                                                        input logic [1:0]  lane);
        logic [SAMPLE_W-1:0] s;
        s = SAMPLE_W'(word >> (int'(lane) * SAMPLE_W));
`ifdef FLASH_LOADER_OFFSET_BIN_EN
        s[SAMPLE_W-1] = ~s[SAMPLE_W-1];
`endif
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        read_d  = read_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wren_d  = 1'b0;
        lane_d  = lane_q;
        word_d  = word_q;
        smp_d   = smp_q;
        data_d  = data_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_REQ;
                    addr_d  = bus.start_addr;
                    smp_d   = '0;
                    word_d  = '0;
                    read_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_REQ: begin
                if (read_q && !bus.flash_mem_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Lane 0 is issued straight from the bus so the first write lands one cycle after valid.
                if (bus.flash_mem_readdatavalid) begin
                    hold_d  = bus.flash_mem_readdata;
                    data_d  = lane_sample(bus.flash_mem_readdata, 2'd0);
                    wren_d  = 1'b1;
                    lane_d  = 2'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                smp_d = smp_q + MEM_AW'(1);
                if (lane_q == LAST_LANE) begin
                    addr_d = addr_q + FLASH_AW'(1);
                    if (word_q == LAST_WORD) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        word_d  = word_q + MEM_AW'(1);
                        read_d  = 1'b1;
                        state_d = S_REQ;
                    end
                end else begin
                    lane_d = lane_q + 2'd1;
                    data_d = lane_sample(hold_q, lane_q + 2'd1);
                    wren_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wren_q  <= 1'b0;
            lane_q  <= 2'd0;
            word_q  <= '0;
            smp_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wren_q  <= wren_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
        end
    end

    // Holding register is pure datapath; it is always loaded before it is read.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
    assign bus.flash_mem_read       = read_q;
    assign bus.flash_mem_address    = addr_q;
    assign bus.flash_mem_byteenable = 4'b1111;
    assign bus.s_mem_address        = smp_q;
    assign bus.s_mem_data           = data_q;
    assign bus.s_mem_wren           = wren_q;
endmodule

// File: tb/tb_flash_sample_loader.sv
// Scoreboard bench for flash_sample_loader: instance A (16-bit, 256 deep), instance B (8-bit, 16 deep).
`timescale 1ns/1ps
module tb_flash_sample_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flash_sample_loader_if #(.SAMPLE_W(16), .MEM_AW(8), .FLASH_AW(23)) ifa ();
    flash_sample_loader_if #(.SAMPLE_W(8),  .MEM_AW(4), .FLASH_AW(23)) ifb ();

    flash_sample_loader #(.SAMPLE_W(16), .MEM_AW(8), .FLASH_AW(23)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    flash_sample_loader #(.SAMPLE_W(8),  .MEM_AW(4), .FLASH_AW(23)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_rd_a[$];
    logic [31:0] exp_wr_a[$];
    logic [31:0] exp_rd_b[$];
    logic [31:0] exp_wr_b[$];
    int a_wait = 0, a_lat = 1, a_mode = 0, a_acc = 0, a_done = 0;
    int b_wait = 0, b_lat = 1, b_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event, value 0x%0h", name, act);
    endtask

    // Flash contents: A word n = {2n+1, 2n} (mode 0) or 0x80000000 (mode 1);
    // B word at address a = bytes {a+34h, a+23h, a+12h, a+01h} of the low address byte.
    function automatic logic [31:0] word_a(input logic [22:0] a);
        logic [15:0] lo;
        lo = 16'(a) << 1;
        return (a_mode == 1) ? 32'h8000_0000 : {lo + 16'd1, lo};
    endfunction

    function automatic logic [31:0] word_b(input logic [22:0] a);
        logic [7:0] l;
        l = a[7:0];
        return {l + 8'h34, l + 8'h23, l + 8'h12, l + 8'h01};
    endfunction

    function automatic logic [15:0] fix16(input logic [15:0] s);
`ifdef FLASH_LOADER_OFFSET_BIN_EN
        return s ^ 16'h8000;
`else
        return s;
`endif
    endfunction

    function automatic logic [7:0] fix8(input logic [7:0] s);
`ifdef FLASH_LOADER_OFFSET_BIN_EN
        return s ^ 8'h80;
`else
        return s;
`endif
    endfunction

    // Flash responders: waitrequest for *_wait cycles, then valid *_lat cycles after acceptance.
    initial begin
        logic in_req; int wleft; int pend; logic [22:0] paddr;
        in_req = 1'b0; wleft = 0; pend = 0; paddr = '0;
        ifa.flash_mem_waitrequest = 1'b0;
        ifa.flash_mem_readdata = '0;
        ifa.flash_mem_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            ifa.flash_mem_readdatavalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ifa.flash_mem_readdata = word_a(paddr);
                    ifa.flash_mem_readdatavalid = 1'b1;
                end
            end
            ifa.flash_mem_waitrequest = 1'b0;
            if (ifa.flash_mem_read) begin
                if (!in_req) begin
                    in_req = 1'b1; wleft = a_wait; paddr = ifa.flash_mem_address;
                end
                if (wleft > 0) begin
                    wleft--; ifa.flash_mem_waitrequest = 1'b1;
                end else begin
                    in_req = 1'b0; pend = a_lat; a_acc++;
                end
            end
        end
    end

    initial begin
        logic in_req; int wleft; int pend; logic [22:0] paddr;
        in_req = 1'b0; wleft = 0; pend = 0; paddr = '0;
        ifb.flash_mem_waitrequest = 1'b0;
        ifb.flash_mem_readdata = '0;
        ifb.flash_mem_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            ifb.flash_mem_readdatavalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ifb.flash_mem_readdata = word_b(paddr);
                    ifb.flash_mem_readdatavalid = 1'b1;
                end
            end
            ifb.flash_mem_waitrequest = 1'b0;
            if (ifb.flash_mem_read) begin
                if (!in_req) begin
                    in_req = 1'b1; wleft = b_wait; paddr = ifb.flash_mem_address;
                end
                if (wleft > 0) begin
                    wleft--; ifb.flash_mem_waitrequest = 1'b1;
                end else begin
                    in_req = 1'b0; pend = b_lat;
                end
            end
        end
    end

    // Monitors: pop expected reads/writes whenever the DUT presents them.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                if (ifa.flash_mem_read) begin
                    if (exp_rd_a.size() == 0) flag("a_read", 32'(ifa.flash_mem_address));
                    else if (ifa.flash_mem_waitrequest)
                        check("a_addr_hold", 32'(ifa.flash_mem_address), exp_rd_a[0]);
                    else check("a_read_addr", 32'(ifa.flash_mem_address), exp_rd_a.pop_front());
                end
                if (ifa.s_mem_wren) begin
                    if (exp_wr_a.size() == 0) flag("a_write", 32'({ifa.s_mem_address, ifa.s_mem_data}));
                    else check("a_write", 32'({ifa.s_mem_address, ifa.s_mem_data}), exp_wr_a.pop_front());
                end
                if (ifa.done) a_done++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                if (ifb.flash_mem_read) begin
                    if (exp_rd_b.size() == 0) flag("b_read", 32'(ifb.flash_mem_address));
                    else if (ifb.flash_mem_waitrequest)
                        check("b_addr_hold", 32'(ifb.flash_mem_address), exp_rd_b[0]);
                    else check("b_read_addr", 32'(ifb.flash_mem_address), exp_rd_b.pop_front());
                end
                if (ifb.s_mem_wren) begin
                    if (exp_wr_b.size() == 0) flag("b_write", 32'({ifb.s_mem_address, ifb.s_mem_data}));
                    else check("b_write", 32'({ifb.s_mem_address, ifb.s_mem_data}), exp_wr_b.pop_front());
                end
                if (ifb.done) b_done++;
            end
        end
    end

    task automatic run_a(input int w, input int l, input int mode, input int mid_start);
        int d0;
        bit seen;
        a_wait = w; a_lat = l; a_mode = mode;
        for (int n = 0; n < 128; n++) exp_rd_a.push_back(32'(n));
        for (int i = 0; i < 256; i++) begin
            logic [15:0] d;
            d = (mode == 1) ? (((i % 2) == 1) ? 16'h8000 : 16'h0000) : 16'(i);
            exp_wr_a.push_back(32'({8'(i), fix16(d)}));
        end
        d0 = a_done;
        @(negedge clk); ifa.start = 1'b1; ifa.start_addr = 23'h0;
        @(negedge clk); ifa.start = 1'b0;
        #1;
        check("a_read_rise", 32'(ifa.flash_mem_read), 32'd1);
        check("a_busy_rise", 32'(ifa.busy), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk); #3;
            if (ifa.flash_mem_readdatavalid) seen = 1'b1;
        end
        if (!seen) flag("a_rdv_timeout", 32'd0);
        @(negedge clk); #3;
        check("a_first_wren", 32'(ifa.s_mem_wren), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge clk);
            ifa.start = (mid_start != 0) && (c == 40);
            ifa.start_addr = 23'h55;
            #3;
            if (a_done != d0) seen = 1'b1;
        end
        ifa.start = 1'b0;
        if (!seen) flag("a_done_timeout", 32'(a_done));
        else begin
            check("a_done_busy_low", 32'(ifa.busy), 32'd0);
            check("a_done_saddr", 32'(ifa.s_mem_address), 32'd0);
            @(negedge clk); #3;
            check("a_done_width", 32'(ifa.done), 32'd0);
        end
        repeat (4) @(negedge clk);
        check("a_done_count", 32'(a_done - d0), 32'd1);
        check("a_reads_left", 32'(exp_rd_a.size()), 32'd0);
        check("a_writes_left", 32'(exp_wr_a.size()), 32'd0);
        exp_rd_a.delete(); exp_wr_a.delete();
    endtask

    task automatic abort_a();
        int acc0;
        a_wait = 0; a_lat = 3; a_mode = 0;
        exp_rd_a.push_back(32'h200);
        acc0 = a_acc;
        @(negedge clk); ifa.start = 1'b1; ifa.start_addr = 23'h200;
        @(negedge clk); ifa.start = 1'b0;
        for (int c = 0; c < 20 && a_acc == acc0; c++) begin
            #3;
            if (a_acc == acc0) @(negedge clk);
        end
        if (a_acc == acc0) flag("a_abort_accept_timeout", 32'd0);
        @(posedge clk); #1;
        check("a_wait_busy", 32'(ifa.busy), 32'd1);
        check("a_wait_read_low", 32'(ifa.flash_mem_read), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(ifa.busy), 32'd0);
        check("rst_done", 32'(ifa.done), 32'd0);
        check("rst_read", 32'(ifa.flash_mem_read), 32'd0);
        check("rst_wren", 32'(ifa.s_mem_wren), 32'd0);
        check("rst_faddr", 32'(ifa.flash_mem_address), 32'd0);
        check("rst_saddr", 32'(ifa.s_mem_address), 32'd0);
        check("rst_sdata", 32'(ifa.s_mem_data), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        check("late_rdv_wren", 32'(ifa.s_mem_wren), 32'd0);
        check("late_rdv_busy", 32'(ifa.busy), 32'd0);
        check("late_rdv_saddr", 32'(ifa.s_mem_address), 32'd0);
        check("a_abort_reads_left", 32'(exp_rd_a.size()), 32'd0);
        exp_rd_a.delete(); exp_wr_a.delete();
    endtask

    task automatic run_b(input logic [22:0] sa, input int w, input int l);
        int d0;
        bit seen;
        b_wait = w; b_lat = l;
        for (int n = 0; n < 4; n++) begin
            logic [22:0] a;
            a = sa + 23'(n);
            exp_rd_b.push_back(32'(a));
            for (int k = 0; k < 4; k++)
                exp_wr_b.push_back(32'({4'(4 * n + k), fix8(a[7:0] + 8'h01 + 8'(17 * k))}));
        end
        d0 = b_done;
        @(negedge clk); ifb.start = 1'b1; ifb.start_addr = sa;
        @(negedge clk); ifb.start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk); #3;
            if (b_done != d0) seen = 1'b1;
        end
        if (!seen) flag("b_done_timeout", 32'(b_done));
        else check("b_done_busy_low", 32'(ifb.busy), 32'd0);
        repeat (4) @(negedge clk);
        check("b_done_count", 32'(b_done - d0), 32'd1);
        check("b_reads_left", 32'(exp_rd_b.size()), 32'd0);
        check("b_writes_left", 32'(exp_wr_b.size()), 32'd0);
        exp_rd_b.delete(); exp_wr_b.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.start = 1'b0; ifa.start_addr = '0;
        ifb.start = 1'b0; ifb.start_addr = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(ifa.busy), 32'd0);
        check("reset_done", 32'(ifa.done), 32'd0);
        check("reset_read", 32'(ifa.flash_mem_read), 32'd0);
        check("reset_wren", 32'(ifa.s_mem_wren), 32'd0);
        check("reset_faddr", 32'(ifa.flash_mem_address), 32'd0);
        check("reset_saddr", 32'(ifa.s_mem_address), 32'd0);
        check("reset_sdata", 32'(ifa.s_mem_data), 32'd0);
        check("reset_byteen", 32'(ifa.flash_mem_byteenable), 32'hF);
        check("reset_b_busy", 32'(ifb.busy), 32'd0);
        check("reset_b_byteen", 32'(ifb.flash_mem_byteenable), 32'hF);
        rst = 1'b0;
        run_a(0, 1, 0, 0);
        run_a(3, 2, 0, 1);
        abort_a();
        run_a(0, 1, 1, 0);
        run_b(23'h10, 0, 1);
        run_b(23'h7FFFFF, 1, 2);
        check("byteen_after", 32'(ifa.flash_mem_byteenable), 32'hF);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flash_sample_loader.md
# flash_sample_loader

Parametrised loader that copies a block of 32-bit words from the Avalon-MM flash controller into an on-chip sample memory. Each flash word is split into 32/SAMPLE_W samples, low lane first, each written to consecutive sample-memory addresses. The block sits between the `flash` Qsys instance and the `s_mem` RAM. It replaces the fixed 16-bit, 256-entry, free-running fill with a start/done-controlled, width- and depth-configurable transfer.

## Interface
Parameters:
- `SAMPLE_W`, 16: sample width; legal values 8, 16, 32. SPW = 32/SAMPLE_W samples per flash word.
- `MEM_AW`, 8: sample-memory address width. Depth = 2^MEM_AW samples. Depth must be a multiple of SPW.
- `FLASH_AW`, 23: flash word-address width.

Ports:
- `clk`  in  1  system clock (CLOCK_50)
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle request to begin a transfer; sampled only in IDLE
- `start_addr`  in  FLASH_AW  first flash word address; latched on accepted `start`
- `busy`  out  1  high from the cycle after accepted `start` until DONE
- `done`  out  1  one-cycle pulse when the last sample has been written
- `flash_mem_read`  out  1  Avalon read request
- `flash_mem_address`  out  FLASH_AW  Avalon word address
- `flash_mem_byteenable`  out  4  constant 4'b1111
- `flash_mem_waitrequest`  in  1  Avalon stall
- `flash_mem_readdata`  in  32  Avalon read data
- `flash_mem_readdatavalid`  in  1  read data qualifier
- `s_mem_address`  out  MEM_AW  sample-memory write address
- `s_mem_data`  out  SAMPLE_W  sample-memory write data
- `s_mem_wren`  out  1  sample-memory write enable

## Operation
- States:
  - IDLE → REQ on `start`.
  - REQ → WAIT when `flash_mem_read && !flash_mem_waitrequest`.
  - WAIT → WRITE on `flash_mem_readdatavalid`.
  - WRITE → REQ after SPW writes if more words remain; otherwise WRITE → DONE.
  - DONE → IDLE unconditionally.
- IDLE: on `start`, latch `start_addr`, clear the sample counter and word counter, and go to REQ.
- REQ: hold `flash_mem_read`=1 and the address stable while `flash_mem_waitrequest`=1. Deassert `flash_mem_read` in the cycle after acceptance.
- WAIT: on `flash_mem_readdatavalid`, capture `flash_mem_readdata` into a 32-bit holding register. `flash_mem_readdatavalid` seen in any other state is ignored.
- WRITE: emit SPW writes, one per cycle. Write k (k = 0..SPW-1) drives lane `readdata[k*SAMPLE_W +: SAMPLE_W]` with `s_mem_wren`=1 and `s_mem_address` = sample counter. The sample counter increments after each write. The flash address increments by 1 after the last lane.
- Total words per transfer = 2^MEM_AW / SPW. Completion is detected by the word counter, not by sample-address wrap.
- The sample counter wraps to 0 after the final write. `s_mem_address` reads 0 in DONE and IDLE.
- Flash address arithmetic is modulo 2^FLASH_AW: a transfer starting near the top of flash wraps to 0 without error.
- `start` while `busy` is ignored and has no side effects.
- `rst` mid-transfer returns to IDLE immediately and drives all outputs to their reset values. A late `flash_mem_readdatavalid` from the aborted read is ignored.

## Timing
- Reset values:
  - `busy`, `done`, `flash_mem_read`, `s_mem_wren` = 0
  - `flash_mem_address`, `s_mem_address`, `s_mem_data` = 0
  - `flash_mem_byteenable` = 4'b1111 always
- All outputs are registered.
- `flash_mem_read` rises 1 cycle after accepted `start`.
- First `s_mem_wren` rises 1 cycle after `flash_mem_readdatavalid`.
- Per-word cycles = 1 (REQ, zero waitrequest) + W (waitrequest cycles) + L (flash read latency) + SPW (writes).
- After a word's last write, the next `flash_mem_read` is asserted in the following cycle.
- `done` asserts 1 cycle after the final write, lasts exactly 1 cycle, and `busy` falls in the same cycle.
- Exactly one outstanding read at any time; no pipelining of requests.

## Configuration
- Macro `FLASH_LOADER_OFFSET_BIN_EN`.
- When defined: every sample has its MSB inverted before the write, converting two's-complement audio to offset binary.
- When undefined: samples are written unmodified.

## Test plan
- SAMPLE_W=16, MEM_AW=8, start_addr=0, flash word n = {16'(2n+1), 16'(2n)} → mem[i]=i for i=0..255. Exactly 128 reads at addresses 0..127, then one `done` pulse.
- SAMPLE_W=8, MEM_AW=4, word 0x44332211 at start_addr=0x10 → mem[0..3] = 0x11,0x22,0x33,0x44. 4 reads at addresses 0x10..0x13.
- Waitrequest held 3 cycles on every read → `flash_mem_read` stays high and the address is stable for those 3 cycles. Contents are identical to the zero-wait run.
- start_addr=23'h7FFFFF, MEM_AW=2, SAMPLE_W=16 → reads at 7FFFFF then 000000. `done` asserted.
- `start` pulsed mid-transfer, then `rst` asserted during WAIT → the extra `start` has no effect. After reset, all outputs are 0 and a following `flash_mem_readdatavalid` causes no write.
- `FLASH_LOADER_OFFSET_BIN_EN` defined, word 0x80000000 → mem[0]=0x8000, mem[1]=0x0000.
